// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner: walks one active-low column per scan tick, debounces
// whole-matrix snapshots and reports single-key presses as code/valid/held/release.
module keypad_scanner #(
  parameter int CLK_FREQ       = 12000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_out,
  input  logic [3:0] row_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);

  localparam int TICKS = CLK_FREQ / SCAN_HZ;
  localparam int TW    = $clog2(TICKS);
  localparam int SW    = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    MULTI = 2'd2
  } state_e;

  logic [3:0]    row_meta_q, row_meta_d;
  logic [3:0]    row_sync_q, row_sync_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          snap_done_q, snap_done_d;
  logic [15:0]   prev_q, prev_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [15:0]   deb_q, deb_d;
  logic          deb_upd_q, deb_upd_d;
  state_e        state_q, state_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic          key_release_q, key_release_d;
  logic          tick;
  logic [4:0]    deb_count;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'b0, v[4'(i)]};
    end
    return cnt;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[4'(i)]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Column walk: the tick samples the rows for the column currently driven, then moves on.
  always_comb begin
    row_meta_d  = row_in;
    row_sync_d  = row_meta_q;
    tick        = (tick_cnt_q == TW'(TICKS - 1));
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    col_idx_d   = col_idx_q;
    snap_d      = snap_q;
    snap_done_d = 1'b0;
    if (tick) begin
      col_idx_d = col_idx_q + 2'd1;
      for (int r = 0; r < 4; r++) begin
        snap_d[{2'(r), col_idx_q}] = ~row_sync_q[2'(r)];
      end
      snap_done_d = (col_idx_q == 2'd3);
    end
  end

  assign col_out = ~(4'b0001 << col_idx_q);

  // Debounce runs the cycle after a snapshot completes, so snap_q already holds column 3.
  always_comb begin
    prev_d    = prev_q;
    stable_d  = stable_q;
    deb_d     = deb_q;
    deb_upd_d = 1'b0;
    if (snap_done_q) begin
      prev_d = snap_q;
      if (snap_q == prev_q) begin
        if (stable_q != STABLE_MAX) stable_d = stable_q + SW'(1);
      end else begin
        stable_d = '0;
      end
      if (stable_d == STABLE_MAX) begin
        deb_d     = snap_q;
        deb_upd_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    key_held_d    = key_held_q;
    deb_count     = popcount16(deb_q);
    if (deb_upd_q) begin
      case (state_q)
        IDLE: begin
          if (deb_count == 5'd1) begin
            state_d     = HELD;
            key_code_d  = lowest_set(deb_q);
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
          end else if (deb_count > 5'd1) begin
            state_d = MULTI;
          end
        end
        HELD: begin
          if (deb_count == 5'd0) begin
            state_d       = IDLE;
            key_release_d = 1'b1;
            key_held_d    = 1'b0;
          end else if (deb_q != (16'h0001 << key_code_q)) begin
            // A changed or extra key invalidates the hold silently.
            state_d    = MULTI;
            key_held_d = 1'b0;
          end
        end
        MULTI: begin
          if (deb_count == 5'd0) state_d = IDLE;
        end
        default: begin
          state_d    = IDLE;
          key_held_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q    <= 4'hF;
      row_sync_q    <= 4'hF;
      tick_cnt_q    <= '0;
      col_idx_q     <= 2'd0;
      snap_q        <= '0;
      snap_done_q   <= 1'b0;
      prev_q        <= '0;
      stable_q      <= '0;
      deb_q         <= '0;
      deb_upd_q     <= 1'b0;
      state_q       <= IDLE;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      row_meta_q    <= row_meta_d;
      row_sync_q    <= row_sync_d;
      tick_cnt_q    <= tick_cnt_d;
      col_idx_q     <= col_idx_d;
      snap_q        <= snap_d;
      snap_done_q   <= snap_done_d;
      prev_q        <= prev_d;
      stable_q      <= stable_d;
      deb_q         <= deb_d;
      deb_upd_q     <= deb_upd_d;
      state_q       <= state_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: 16 clocks per column, 64 per scan, two-scan debounce,
// with a key-matrix model that pulls a row low when its key is pressed and its column is driven.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_out;
  logic [3:0]  row_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        key_release;
  logic [15:0] keys;

  int checks;
  int failures;
  int pulse_viol;
  logic prev_pulse;

  keypad_scanner #(
    .CLK_FREQ(1600),
    .SCAN_HZ(100),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .col_out(col_out),
    .row_in(row_in),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4'(r * 4 + c)] && !col_out[2'(c)]) row_in[2'(r)] = 1'b0;
      end
    end
  end

  // Advances n clocks sampling on the falling edge; tallies pulses and held cycles.
  task automatic run_cycles(input int n, output int valids, output int releases, output int held_hi);
    valids   = 0;
    releases = 0;
    held_hi  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_valid) valids++;
      if (key_release) releases++;
      if (key_held) held_hi++;
      if (key_valid && key_release) pulse_viol++;
      if ((key_valid || key_release) && prev_pulse) pulse_viol++;
      prev_pulse = key_valid || key_release;
    end
  endtask

  task automatic test_reset();
    int bad_col;
    int bad_out;
    logic [3:0] exp_col;
    rst_n = 1'b0;
    keys  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (col_out !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL reset_col_out got=%b want=1110", col_out);
    end
    checks++;
    if ({key_code, key_valid, key_held, key_release} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got code=%0d v=%b h=%b r=%b want all 0",
               key_code, key_valid, key_held, key_release);
    end
    rst_n   = 1'b1;
    bad_col = 0;
    bad_out = 0;
    for (int k = 0; k < 640; k++) begin
      exp_col = ~(4'b0001 << ((k / 16) % 4));
      if (col_out !== exp_col) bad_col++;
      if ({key_code, key_valid, key_held, key_release} !== 7'b0) bad_out++;
      @(negedge clk);
    end
    checks++;
    if (bad_col !== 0) begin
      failures++;
      $display("[TB] FAIL idle_col_sequence bad_cycles=%0d want=0", bad_col);
    end
    checks++;
    if (bad_out !== 0) begin
      failures++;
      $display("[TB] FAIL idle_outputs_quiet bad_cycles=%0d want=0", bad_out);
    end
  endtask

  task automatic test_press_hold();
    int v, r, h;
    keys[6] = 1'b1;
    run_cycles(196, v, r, h);
    checks++;
    if (v !== 1) begin
      failures++;
      $display("[TB] FAIL press6_valid_count got=%0d want=1", v);
    end
    checks++;
    if (key_code !== 4'd6) begin
      failures++;
      $display("[TB] FAIL press6_code got=%0d want=6", key_code);
    end
    checks++;
    if (key_held !== 1'b1) begin
      failures++;
      $display("[TB] FAIL press6_held got=%b want=1", key_held);
    end
    run_cycles(320, v, r, h);
    checks++;
    if ((v + r) !== 0) begin
      failures++;
      $display("[TB] FAIL hold6_no_pulses got=%0d want=0", v + r);
    end
    checks++;
    if (h !== 320) begin
      failures++;
      $display("[TB] FAIL hold6_held_cycles got=%0d want=320", h);
    end
  endtask

  task automatic test_release();
    int v, r, h;
    keys[6] = 1'b0;
    run_cycles(196, v, r, h);
    checks++;
    if (r !== 1) begin
      failures++;
      $display("[TB] FAIL release6_pulse_count got=%0d want=1", r);
    end
    checks++;
    if (v !== 0) begin
      failures++;
      $display("[TB] FAIL release6_no_valid got=%0d want=0", v);
    end
    checks++;
    if (key_held !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release6_held got=%b want=0", key_held);
    end
    checks++;
    if (key_code !== 4'd6) begin
      failures++;
      $display("[TB] FAIL release6_code_kept got=%0d want=6", key_code);
    end
  endtask

  task automatic test_bounce();
    int v1, r1, h1, v2, r2, h2;
    keys[12] = 1'b1;
    run_cycles(64, v1, r1, h1);
    keys[12] = 1'b0;
    run_cycles(256, v2, r2, h2);
    checks++;
    if ((v1 + v2 + r1 + r2) !== 0) begin
      failures++;
      $display("[TB] FAIL bounce12_no_pulses got=%0d want=0", v1 + v2 + r1 + r2);
    end
    checks++;
    if ((h1 + h2) !== 0) begin
      failures++;
      $display("[TB] FAIL bounce12_never_held got=%0d want=0", h1 + h2);
    end
  endtask

  task automatic test_multi();
    int v, r, h;
    keys[1]  = 1'b1;
    keys[10] = 1'b1;
    run_cycles(256, v, r, h);
    checks++;
    if ((v + r + h) !== 0) begin
      failures++;
      $display("[TB] FAIL multi_1_10_quiet got=%0d want=0", v + r + h);
    end
    keys[10] = 1'b0;
    run_cycles(256, v, r, h);
    checks++;
    if ((v + r + h) !== 0) begin
      failures++;
      $display("[TB] FAIL multi_drop_to_1_quiet got=%0d want=0", v + r + h);
    end
    keys = '0;
    run_cycles(256, v, r, h);
    checks++;
    if ((v + r + h) !== 0) begin
      failures++;
      $display("[TB] FAIL multi_release_all_quiet got=%0d want=0", v + r + h);
    end
    keys[15] = 1'b1;
    run_cycles(196, v, r, h);
    checks++;
    if (v !== 1) begin
      failures++;
      $display("[TB] FAIL press15_valid_count got=%0d want=1", v);
    end
    checks++;
    if (key_code !== 4'd15) begin
      failures++;
      $display("[TB] FAIL press15_code got=%0d want=15", key_code);
    end
    keys[15] = 1'b0;
    run_cycles(256, v, r, h);
    checks++;
    if (r !== 1) begin
      failures++;
      $display("[TB] FAIL release15_pulse_count got=%0d want=1", r);
    end
  endtask

  task automatic test_reset_midscan();
    int v, r, h;
    keys[5] = 1'b1;
    run_cycles(196, v, r, h);
    checks++;
    if (v !== 1 || key_code !== 4'd5 || key_held !== 1'b1) begin
      failures++;
      $display("[TB] FAIL press5_before_reset got v=%0d code=%0d held=%b want 1/5/1", v, key_code, key_held);
    end
    run_cycles(20, v, r, h);
    rst_n = 1'b0;
    #1;
    checks++;
    if (col_out !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL midreset_col_out got=%b want=1110", col_out);
    end
    checks++;
    if ({key_code, key_valid, key_held, key_release} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got code=%0d v=%b h=%b r=%b want all 0",
               key_code, key_valid, key_held, key_release);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (col_out !== 4'b1110 || key_held !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_held_low got col=%b held=%b want 1110/0", col_out, key_held);
    end
    prev_pulse = 1'b0;
    rst_n = 1'b1;
    run_cycles(196, v, r, h);
    checks++;
    if (v !== 1) begin
      failures++;
      $display("[TB] FAIL repress5_valid_count got=%0d want=1", v);
    end
    checks++;
    if (key_code !== 4'd5 || key_held !== 1'b1) begin
      failures++;
      $display("[TB] FAIL repress5_code_held got code=%0d held=%b want 5/1", key_code, key_held);
    end
    keys = '0;
  endtask

  task automatic test_back_to_back();
    checks++;
    if (pulse_viol !== 0) begin
      failures++;
      $display("[TB] FAIL pulse_spacing violations=%0d want=0", pulse_viol);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    pulse_viol = 0;
    prev_pulse = 1'b0;
    keys       = '0;
    rst_n      = 1'b0;
    test_reset();
    test_press_hold();
    test_release();
    test_bounce();
    test_multi();
    test_reset_midscan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
